// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with memory wait handshake, timeout/illegal traps and retire counter.
// Defining MULTICYCLE_JAL_EN adds jal (opcode 000011) through the JUMP state, writing PC to $31.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             rtype,
    output logic             invertzero,
    output logic             zeroext,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic [3:0]       aluop,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEXEC = 4'd6, S_RTWB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP = 4'd9, S_IMMEXEC = 4'd10, S_IMMWB = 4'd11,
        S_TRAP = 4'd15
    } state_t;

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       regwrite, alusrca, rtype, invertzero, zeroext;
        logic [1:0] regdst, memtoreg, alusrcb, pcsource;
        logic [3:0] aluop;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_J  = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t              cur_state, next_state;
    ctrl_t               ctrl_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                waiting, limit_hit, trap_illegal, trap_timeout, retire;

    function automatic ctrl_t decode(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c       = '0;
        c.aluop = 4'b0010;
        case (st)
            S_FETCH:   begin c.memread = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   begin c.memread = 1'b1; c.iord = 1'b1; end
            S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 2'b01; end
            S_MEMWR:   begin c.memwrite = 1'b1; c.iord = 1'b1; end
            S_RTEXEC:  begin c.alusrca = 1'b1; c.rtype = 1'b1; end
            S_RTWB:    begin c.regwrite = 1'b1; c.regdst = 2'b01; end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = 4'b0110;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.invertzero  = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
`ifdef MULTICYCLE_JAL_EN
                if (op == OP_JAL) begin
                    c.regwrite = 1'b1;
                    c.regdst   = 2'b10;
                    c.memtoreg = 2'b10;
                end
`endif
            end
            S_IMMEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                if (op == OP_ORI) begin
                    c.aluop   = 4'b0001;
                    c.zeroext = 1'b1;
                end
            end
            S_IMMWB:   c.regwrite = 1'b1;
            default:   ;
        endcase
        return c;
    endfunction

    assign waiting   = (cur_state == S_FETCH || cur_state == S_MEMRD || cur_state == S_MEMWR) && !mem_ready;
    assign limit_hit = (MEM_TIMEOUT != 0) && (int'(wait_cnt) == MEM_TIMEOUT - 1);

    // NOTE: every variable in this block gets a default first, so no latch can be inferred.
    always_comb begin
        next_state   = cur_state;
        trap_illegal = 1'b0;
        trap_timeout = 1'b0;
        retire       = 1'b0;
        case (cur_state)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    case (cur_state)
                        S_FETCH: next_state = S_DECODE;
                        S_MEMRD: next_state = S_MEMWB;
                        default: begin next_state = S_FETCH; retire = 1'b1; end
                    endcase
                end else if (limit_hit) begin
                    next_state   = S_TRAP;
                    trap_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                   next_state = S_RTEXEC;
                    OP_LW, OP_SW:               next_state = S_MEMADR;
                    OP_BEQ, OP_BNE:             next_state = S_BRANCH;
                    OP_J:                       next_state = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:                     next_state = S_JUMP;
`endif
                    OP_ADDI, OP_ADDIU, OP_ORI:  next_state = S_IMMEXEC;
                    default: begin next_state = S_TRAP; trap_illegal = 1'b1; end
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_RTEXEC:  next_state = S_RTWB;
            S_IMMEXEC: next_state = S_IMMWB;
            S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_IMMWB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default:   next_state = S_TRAP;
        endcase
    end

    // NOTE: outputs are decoded from next_state and registered here, so each state's controls are glitch-free from its first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
            ctrl_q    <= decode(S_FETCH, opcode);
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
            instret   <= '0;
        end else begin
            cur_state <= next_state;
            ctrl_q    <= decode(next_state, opcode);
            wait_cnt  <= (waiting && next_state == cur_state) ? wait_cnt + 1'b1 : '0;
            if (trap_illegal) illegal <= 1'b1;
            if (trap_timeout) timeout <= 1'b1;
            if (retire)       instret <= instret + 1'b1;
        end
    end

    // Write strobes are gated by reset so nothing is written while reset is held.
    assign pcwrite     = !reset && (ctrl_q.pcwrite || (cur_state == S_FETCH && mem_ready));
    assign irwrite     = !reset && cur_state == S_FETCH && mem_ready;
    assign pcwritecond = !reset && ctrl_q.pcwritecond;
    assign regwrite    = !reset && ctrl_q.regwrite;
    assign memwrite    = !reset && ctrl_q.memwrite;
    assign memread     = !reset && ctrl_q.memread;
    assign iord        = ctrl_q.iord;
    assign alusrca     = ctrl_q.alusrca;
    assign rtype       = ctrl_q.rtype;
    assign invertzero  = ctrl_q.invertzero;
    assign zeroext     = ctrl_q.zeroext;
    assign regdst      = ctrl_q.regdst;
    assign memtoreg    = ctrl_q.memtoreg;
    assign alusrcb     = ctrl_q.alusrcb;
    assign pcsource    = ctrl_q.pcsource;
    assign aluop       = ctrl_q.aluop;
    assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_TIMEOUT=4, CNT_W=4 so wrap is reachable).
module tb_multicycle_control;

    localparam int CNT_W = 4;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] JAL = 6'b000011, BAD = 6'b111111;

    logic             clk = 1'b0;
    logic             reset, mem_ready;
    logic [5:0]       opcode;
    logic             pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite;
    logic             alusrca, rtype, invertzero, zeroext, illegal, timeout;
    logic [1:0]       regdst, memtoreg, alusrcb, pcsource;
    logic [3:0]       aluop, state;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] exp_ret;
    int               total = 0;
    int               bad = 0;
    int               regw, irw, rt;

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
        .rtype(rtype), .invertzero(invertzero), .zeroext(zeroext), .regdst(regdst),
        .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsource(pcsource), .aluop(aluop),
        .state(state), .illegal(illegal), .timeout(timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH; mem_ready is low for the first `delay` cycles.
    task automatic run_instr(input string tag, input logic [5:0] op, input int delay, input int exp_cycles,
                             output int n_regw, output int n_irw, output int n_rt);
        int  cycles;
        bit  left;
        cycles = 0;
        left   = 1'b0;
        n_regw = 0;
        n_irw  = 0;
        n_rt   = 0;
        opcode = op;
        while (cycles < 40) begin
            mem_ready = (cycles >= delay);
            #1;
            if (regwrite) n_regw++;
            if (irwrite)  n_irw++;
            if (rtype)    n_rt++;
            tick();
            cycles++;
            if (state != 4'd0) left = 1'b1;
            if (left && state == 4'd0) break;
        end
        mem_ready = 1'b1;
        check({tag, "_cycles"}, cycles, exp_cycles);
    endtask

    initial begin
        opcode    = LW;
        reset     = 1'b1;
        mem_ready = 1'b1;
        exp_ret   = '0;
        tick();
        check("rst_state", state, 0);
        check("rst_memread", memread, 0);
        check("rst_pcwrite", pcwrite, 0);
        check("rst_irwrite", irwrite, 0);
        check("rst_instret", instret, 0);
        check("rst_traps", {illegal, timeout}, 0);

        // lw walk-through
        reset = 1'b0;
        #1;
        check("lw_f_memread", memread, 1);
        check("lw_f_pcwrite", pcwrite, 1);
        check("lw_f_irwrite", irwrite, 1);
        check("lw_f_alusrcb", alusrcb, 2'b01);
        check("lw_f_iord", iord, 0);
        tick();
        check("lw_d_state", state, 1);
        check("lw_d_alusrcb", alusrcb, 2'b11);
        check("lw_d_memread", memread, 0);
        tick();
        check("lw_ma_state", state, 2);
        check("lw_ma_src", {alusrca, alusrcb}, 3'b110);
        tick();
        check("lw_mr_state", state, 3);
        check("lw_mr_ctl", {memread, iord}, 2'b11);
        tick();
        check("lw_wb_state", state, 4);
        check("lw_wb_ctl", {regwrite, regdst, memtoreg}, 5'b1_00_01);
        tick();
        exp_ret++;
        check("lw_end_state", state, 0);
        check("lw_end_regwrite", regwrite, 0);
        check("lw_instret", instret, exp_ret);

        // R-type with three stalled fetch cycles
        run_instr("rt_stall", RT, 3, 7, regw, irw, rt);
        exp_ret++;
        check("rt_irwrite_pulses", irw, 1);
        check("rt_rtype_cycles", rt, 1);
        check("rt_regwrite_cycles", regw, 1);
        check("rt_instret", instret, exp_ret);

        run_instr("sw", SW, 0, 4, regw, irw, rt);
        exp_ret++;
        check("sw_regwrite_cycles", regw, 0);
        run_instr("addi", ADDI, 0, 4, regw, irw, rt);
        exp_ret++;
        check("addi_instret", instret, exp_ret);

        // ori: zero-extended OR in IMMEXEC
        opcode = ORI;
        tick();
        tick();
        check("ori_state", state, 10);
        check("ori_aluop", aluop, 4'b0001);
        check("ori_zeroext", zeroext, 1);
        tick();
        check("ori_wb", {state, regwrite, regdst, memtoreg}, {4'd11, 5'b1_00_00});
        check("ori_wb_aluop", aluop, 4'b0010);
        tick();
        exp_ret++;

        // bne and beq
        opcode = BNE;
        tick();
        tick();
        check("bne_state", state, 8);
        check("bne_invertzero", invertzero, 1);
        check("bne_ctl", {pcwritecond, pcwrite, pcsource}, 4'b1_0_01);
        check("bne_aluop", aluop, 4'b0110);
        tick();
        exp_ret++;
        check("bne_back", state, 0);
        opcode = BEQ;
        tick();
        tick();
        check("beq_invertzero", {state, invertzero}, {4'd8, 1'b0});
        tick();
        exp_ret++;

        // j
        opcode = J;
        tick();
        tick();
        check("j_ctl", {state, pcwrite, pcsource, regwrite}, {4'd9, 1'b1, 2'b10, 1'b0});
        tick();
        exp_ret++;
        check("j_instret", instret, exp_ret);

        // sw stuck in MEMWR: trap after 4 wait cycles
        opcode = SW;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("to_memwr", {state, memwrite}, {4'd5, 1'b1});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_waiting", state, 5);
        end
        tick();
        check("to_trap_state", state, 15);
        check("to_timeout", timeout, 1);
        check("to_illegal", illegal, 0);
        check("to_memwrite", memwrite, 0);
        check("to_instret", instret, exp_ret);
        mem_ready = 1'b1;
        tick();
        check("to_held", {state, memwrite, memread}, {4'd15, 2'b00});
        do_reset();
        exp_ret = '0;
        check("to_cleared", {state, timeout, illegal}, 0);
        check("to_cleared_instret", instret, 0);

        // mem_ready on the limit cycle wins
        opcode = SW;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        tick();
        exp_ret++;
        check("lim_no_trap", {state, timeout}, 0);
        check("lim_instret", instret, exp_ret);

        // illegal opcode
        opcode = BAD;
        tick();
        tick();
        check("ill_state", state, 15);
        check("ill_flags", {illegal, timeout}, 2'b10);
        check("ill_instret", instret, exp_ret);
        do_reset();
        exp_ret = '0;
        check("ill_cleared", illegal, 0);

        // jal
        opcode = JAL;
        tick();
        tick();
`ifdef MULTICYCLE_JAL_EN
        check("jal_state", state, 9);
        check("jal_ctl", {regwrite, regdst, memtoreg, pcwrite}, 6'b1_10_10_1);
        tick();
        exp_ret++;
        check("jal_instret", {state, instret}, {4'd0, exp_ret});
`else
        check("jal_trap", {state, illegal}, {4'd15, 1'b1});
`endif
        do_reset();
        exp_ret = '0;

        // reset during MEMRD abandons the load
        opcode = LW;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("rmr_state", state, 3);
        reset = 1'b1;
        #1;
        check("rmr_memread_forced", memread, 0);
        tick();
        check("rmr_fetch", state, 0);
        check("rmr_regwrite", regwrite, 0);
        reset = 1'b0;
        #1;
        check("rmr_after_regwrite", regwrite, 0);
        check("rmr_instret", instret, 0);
        mem_ready = 1'b1;

        // instret wraps modulo 2^CNT_W
        for (int i = 0; i < 15; i++) run_instr("wrap_j", J, 0, 3, regw, irw, rt);
        check("wrap_pre", instret, 15);
        run_instr("wrap_j", J, 0, 3, regw, irw, rt);
        check("wrap_post", instret, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS main control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back states, driving the shared-ALU/shared-memory datapath. It replaces the single-cycle opcode decoder. It adds a memory ready/wait handshake, a bounded memory timeout, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register's opcode field and the datapath mux/enable controls; ALU function selection for R-type stays in alucontrol, selected by `rtype`.

## Interface
- `MEM_TIMEOUT`, 16: cycles to wait for `mem_ready` before trapping; 0 disables the timeout.
- `CNT_W`, 32: width of `instret`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from the cycle after the fetch completes.
- `mem_ready` in 1: memory completed the current read/write this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`, `regwrite`, `alusrca`, `rtype`, `invertzero`, `zeroext` out 1: datapath controls.
- `regdst` out 2: 00 rt, 01 rd, 10 $31.
- `memtoreg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `alusrcb` out 2: 00 B, 01 const 4, 10 imm, 11 imm<<2.
- `pcsource` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `aluop` out 4: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt.
- `state` out 4: current state, for debug.
- `illegal`, `timeout` out 1: sticky trap flags.
- `instret` out CNT_W: retired instruction count.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, JUMP 9, IMMEXEC 10, IMMWB 11, TRAP 15.
- Outputs not listed for a state are 0, except `aluop`, which defaults to 0010.
- FETCH: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsource`=00.
  - `pcwrite`=`irwrite`=`mem_ready`.
  - Moves to DECODE when `mem_ready` is high; otherwise stays.
- DECODE: `alusrcb`=11. Dispatch on opcode:
  - 000000 → RTEXEC.
  - 100011 / 101011 → MEMADR.
  - 000100 / 000101 → BRANCH.
  - 000010 → JUMP.
  - 001000 / 001001 / 001101 → IMMEXEC.
  - Any other opcode → TRAP with `illegal` set.
- MEMADR: `alusrca`=1, `alusrcb`=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `memread`=1, `iord`=1. On `mem_ready` → MEMWB.
- MEMWB: `regwrite`=1, `regdst`=00, `memtoreg`=01. → FETCH.
- MEMWR: `memwrite`=1, `iord`=1. On `mem_ready` → FETCH.
- RTEXEC: `alusrca`=1, `alusrcb`=00, `rtype`=1. → RTWB.
- RTWB: `regwrite`=1, `regdst`=01, `memtoreg`=00. → FETCH.
- BRANCH: `alusrca`=1, `aluop`=0110, `pcwritecond`=1, `pcsource`=01, `invertzero`=(opcode==000101). → FETCH.
- JUMP: `pcwrite`=1, `pcsource`=10. → FETCH.
- IMMEXEC: `alusrca`=1, `alusrcb`=10.
  - ori: `aluop`=0001, `zeroext`=1.
  - addi / addiu: `aluop`=0010.
  - → IMMWB.
- IMMWB: `regwrite`=1, `regdst`=00, `memtoreg`=00. → FETCH.
- TRAP: all strobes 0. Held until reset.
- `instret` increments by 1 on the final-state exit of each instruction: MEMWB, MEMWR (with `mem_ready`), RTWB, BRANCH, JUMP, IMMWB. It wraps modulo 2^CNT_W.

## Timing
- Reset:
  - `state`=FETCH, `instret`=0, `illegal`=`timeout`=0, wait counter 0.
  - All write strobes (`pcwrite`, `pcwritecond`, `irwrite`, `regwrite`, `memwrite`, `memread`) are forced to 0 while `reset` is high.
  - Reset mid-instruction abandons the instruction without any write.
- Cycles per instruction with `mem_ready` held high: lw 5, sw 4, R-type 4, addi/addiu/ori 4, beq/bne 3, j 3.
- Each cycle spent in FETCH, MEMRD or MEMWR with `mem_ready` low adds exactly 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each waiting cycle.
  - If `MEM_TIMEOUT`≠0 and the counter reaches `MEM_TIMEOUT` with `mem_ready` still low, the next state is TRAP with `timeout`=1.
  - `mem_ready` arriving in the same cycle the limit is reached wins: the access completes and there is no trap.
- `illegal` and `timeout` are registered: they become 1 in the first TRAP cycle.

## Configuration
- `MULTICYCLE_JAL_EN` defined:
  - Opcode 000011 dispatches to JUMP.
  - JUMP additionally asserts `regwrite`=1, `regdst`=10, `memtoreg`=10, writing the return address to $31.
  - jal takes 3 cycles.
- `MULTICYCLE_JAL_EN` undefined: opcode 000011 is illegal and dispatches to TRAP.

## Test plan
- Reset then lw (100011) with `mem_ready`=1 → states 0,1,2,3,4,0. Exactly one `regwrite` cycle, with `memtoreg`=01. `instret`=1.
- R-type with `mem_ready` low 3 cycles in FETCH → FETCH lasts 4 cycles, `irwrite` pulses once, total 7 cycles. `rtype`=1 only in RTEXEC.
- bne (000101) → BRANCH has `invertzero`=1, `pcwritecond`=1, `aluop`=0110. beq → `invertzero`=0.
- `MEM_TIMEOUT`=4, `mem_ready` stuck low in MEMWR → TRAP after 4 wait cycles. `timeout`=1, `memwrite`=0 thereafter, `instret` unchanged. Reset clears the trap.
- Opcode 111111 → TRAP from DECODE, `illegal`=1. jal (000011) → TRAP without the macro. With the macro: JUMP with `regdst`=10, `memtoreg`=10, `regwrite`=1.
- Reset asserted in MEMRD → next state FETCH, no `regwrite` issued, `instret`=0.
